// File: rtl/icache_pkg.sv
// Shared types and tree-PLRU helpers for the N-way i-cache controller.
// The tree is stored as up to 3 bits: bit0 = root, bit1 = left pair, bit2 = right pair.
package icache_pkg;

    typedef enum logic [1:0] {
        CHECK   = 2'd0,
        REFILL  = 2'd1,
        INSTALL = 2'd2,
        INVAL   = 2'd3
    } icache_state_t;

    localparam int PLRU_MAX_W = 3;

    // Follow the pointers from the root; a 0 bit points to the left subtree.
    function automatic logic [1:0] plru_victim(input int ways, input logic [PLRU_MAX_W-1:0] bits);
        logic [1:0] v;
        if (ways == 2) begin
            v = {1'b0, bits[0]};
        end else if (!bits[0]) begin
            v = {1'b0, bits[1]};
        end else begin
            v = {1'b1, bits[2]};
        end
        return v;
    endfunction

    // Make every node on the path to 'way' point away from it.
    function automatic logic [PLRU_MAX_W-1:0] plru_touch(input int ways,
                                                         input logic [PLRU_MAX_W-1:0] bits,
                                                         input logic [1:0] way);
        logic [PLRU_MAX_W-1:0] b;
        b = bits;
        if (ways == 2) begin
            b[0] = ~way[0];
        end else begin
            b[0] = ~way[1];
            if (!way[1]) begin
                b[1] = ~way[0];
            end else begin
                b[2] = ~way[0];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree-PLRU storage: one combinational victim read port, one touch port, one set-clear port.
module icache_plru
    import icache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [$clog2(SETS)-1:0] rd_set_i,
    output logic [$clog2(WAYS)-1:0] victim_o,
    input  logic                    upd_en_i,
    input  logic [$clog2(SETS)-1:0] upd_set_i,
    input  logic [$clog2(WAYS)-1:0] upd_way_i,
    input  logic                    clr_en_i,
    input  logic [$clog2(SETS)-1:0] clr_set_i
);

    localparam int PW   = WAYS - 1;
    localparam int WIDX = $clog2(WAYS);

    logic [PW-1:0] plru_q [SETS];

    // Clear and touch never coincide in the controller; clear wins if they ever do.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (clr_en_i) begin
            plru_q[clr_set_i] <= '0;
        end else if (upd_en_i) begin
            plru_q[upd_set_i] <= PW'(plru_touch(WAYS, PLRU_MAX_W'(plru_q[upd_set_i]), 2'(upd_way_i)));
        end
    end

    assign victim_o = WIDX'(plru_victim(WAYS, PLRU_MAX_W'(plru_q[rd_set_i])));

endmodule

// File: rtl/icache_ctrl_nway.sv
// N-way i-cache control FSM: hit/miss handling, multi-beat refill, install and full invalidate sweep.
// Optional ICACHE_PERF_EN adds saturating hit_count/miss_count outputs.
module icache_ctrl_nway
    import icache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int BEATS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_read,
    input  logic [$clog2(SETS)-1:0]  set_idx,
    input  logic [WAYS-1:0]          hit_way,
    output logic                     mem_resp,
    output logic                     pmem_read,
    input  logic                     pmem_resp,
    output logic [$clog2(BEATS)-1:0] beat,
    output logic [WAYS-1:0]          way_sel,
    output logic                     data_we,
    output logic                     tag_we,
    input  logic                     inval_req,
    output logic                     valid_clr,
    output logic [$clog2(SETS)-1:0]  inval_set,
    output logic                     inval_done,
    output logic [1:0]               dbg_state
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int SW   = $clog2(SETS);
    localparam int BW   = $clog2(BEATS);
    localparam int WIDX = $clog2(WAYS);

    icache_state_t   state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   set_q, set_d;
    logic [WIDX-1:0] victim_q, victim_d;
    logic            pend_q, pend_d;
    logic            rst_done_q;

    logic [WIDX-1:0] hit_idx;
    logic [WIDX-1:0] plru_victim_w;
    logic            hit;
    logic            upd_en;
    logic [SW-1:0]   upd_set;
    logic [WIDX-1:0] upd_way;
    logic            clr_en;

    // Multi-hit is a datapath fault; the lowest way index wins.
    always_comb begin
        hit_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) begin
                hit_idx = WIDX'(i);
            end
        end
    end
    assign hit = |hit_way;

    icache_plru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk_i     (clk),
        .rst_ni    (reset),
        .rd_set_i  (set_idx),
        .victim_o  (plru_victim_w),
        .upd_en_i  (upd_en),
        .upd_set_i (upd_set),
        .upd_way_i (upd_way),
        .clr_en_i  (clr_en),
        .clr_set_i (cnt_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CHECK;
            beat_q     <= '0;
            cnt_q      <= '0;
            set_q      <= '0;
            victim_q   <= '0;
            pend_q     <= 1'b0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            set_q      <= set_d;
            victim_q   <= victim_d;
            pend_q     <= pend_d;
            rst_done_q <= 1'b1;
        end
    end

    // The FSM sits idle with every output low during the first cycle after reset release.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cnt_d      = cnt_q;
        set_d      = set_q;
        victim_d   = victim_q;
        pend_d     = pend_q;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        way_sel    = '0;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        valid_clr  = 1'b0;
        inval_done = 1'b0;
        upd_en     = 1'b0;
        upd_set    = set_q;
        upd_way    = victim_q;
        clr_en     = 1'b0;
        if (rst_done_q) begin
            unique case (state_q)
                CHECK: begin
                    if (inval_req || pend_q) begin
                        state_d = INVAL;
                    end else if (mem_read && hit) begin
                        mem_resp = 1'b1;
                        way_sel  = WAYS'(1) << hit_idx;
                        upd_en   = 1'b1;
                        upd_set  = set_idx;
                        upd_way  = hit_idx;
                    end else if (mem_read) begin
                        victim_d = plru_victim_w;
                        set_d    = set_idx;
                        state_d  = REFILL;
                    end
                end
                REFILL: begin
                    pmem_read = 1'b1;
                    way_sel   = WAYS'(1) << victim_q;
                    if (inval_req) begin
                        pend_d = 1'b1;
                    end
                    if (pmem_resp) begin
                        data_we = 1'b1;
                        beat_d  = beat_q + BW'(1);
                        if (beat_q == BW'(BEATS - 1)) begin
                            state_d = INSTALL;
                        end
                    end
                end
                INSTALL: begin
                    tag_we  = 1'b1;
                    way_sel = WAYS'(1) << victim_q;
                    upd_en  = 1'b1;
                    if (inval_req) begin
                        pend_d = 1'b1;
                    end
                    state_d = CHECK;
                end
                INVAL: begin
                    valid_clr = 1'b1;
                    clr_en    = 1'b1;
                    cnt_d     = cnt_q + SW'(1);
                    if (cnt_q == SW'(SETS - 1)) begin
                        inval_done = 1'b1;
                        pend_d     = 1'b0;
                        state_d    = CHECK;
                    end
                end
            endcase
        end
    end

    assign beat      = beat_q;
    assign inval_set = cnt_q;
    assign dbg_state = state_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        miss_ev;

    assign miss_ev = (state_q == CHECK) && (state_d == REFILL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (mem_resp && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_ev && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    a_hit_onehot: assert property (@(posedge clk) disable iff (!reset)
        (rst_done_q && (state_q == CHECK) && mem_read) |-> $onehot0(hit_way));

endmodule
